nios_usb_gpx_conditioner: RTL and testbench

//  Upstream conditioning stage for the MAX3421E GPX pin, between the raw pad and the 1-bit GPX PIO input.

---
 rtl/nios_usb_gpx_conditioner.sv | 127 ++++++++++++
 tb/tb_nios_usb_gpx_conditioner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_usb_gpx_conditioner.sv
// GPX pin conditioner: synchroniser, glitch filter, edge strobes, sticky event flag and IRQ.
// Define NIOS_USB_GPX_EDGE_COUNT_EN to build the accepted-edge counter.
module nios_usb_gpx_conditioner #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int FILTER_W      = 8,
   parameter int EDGE_MODE     = 2,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             gpx_pin,
   input  logic             irq_en,
   input  logic             event_clr,
   input  logic             cnt_clr,
   output logic             gpx_clean,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic             event_flag,
   output logic             irq,
   output logic [CNT_W-1:0] edge_count
);

   typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_t;

   localparam logic [FILTER_W-1:0] FC = FILTER_W'(FILTER_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   state_t                 state_q;
   logic [FILTER_W-1:0]    cnt_q;
   logic [FILTER_W-1:0]    cnt_inc;
   logic                   clean_q;
   logic                   rise_q;
   logic                   fall_q;
   logic                   mism;
   logic                   accept;
   logic                   flag_q;
   logic                   flag_d;
   logic                   ev_set;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], gpx_pin};
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign mism     = sync_out ^ clean_q;
   assign cnt_inc  = cnt_q + FILTER_W'(1);

   always_comb begin
      accept = 1'b0;
      unique case (state_q)
         STABLE:  accept = mism && (FILTER_CYCLES == 1);
         PENDING: accept = mism && (cnt_inc == FC);
         default: accept = 1'b0;
      endcase
   end

   // Pulses are registered alongside the gpx_clean update.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= STABLE;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         rise_q <= accept & sync_out;
         fall_q <= accept & ~sync_out;
         if (accept) begin
            clean_q <= sync_out;
            state_q <= STABLE;
            cnt_q   <= '0;
         end else if (!mism) begin
            state_q <= STABLE;
            cnt_q   <= '0;
         end else begin
            state_q <= PENDING;
            cnt_q   <= cnt_inc;
         end
      end
   end

   always_comb begin
      if (EDGE_MODE == 0)      ev_set = rise_q;
      else if (EDGE_MODE == 1) ev_set = fall_q;
      else                     ev_set = rise_q | fall_q;
   end

   // A set on the same cycle as a clear wins.
   assign flag_d = ev_set | (flag_q & ~event_clr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) flag_q <= 1'b0;
      else          flag_q <= flag_d;
   end

`ifdef NIOS_USB_GPX_EDGE_COUNT_EN
   logic [CNT_W-1:0] ecnt_q;
   logic [CNT_W-1:0] ecnt_d;

   always_comb begin
      ecnt_d = ecnt_q;
      if (cnt_clr)         ecnt_d = '0;
      if (rise_q | fall_q) ecnt_d = ecnt_d + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ecnt_q <= '0;
      else          ecnt_q <= ecnt_d;
   end

   assign edge_count = ecnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign edge_count     = '0;
`endif

   assign gpx_clean  = clean_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign event_flag = flag_q;
   assign irq        = flag_q & irq_en;

endmodule

// File: tb/tb_nios_usb_gpx_conditioner.sv
// Bench for nios_usb_gpx_conditioner: directed tables, hand sequences, random vs. window model.
// Two instances: defaults, and EDGE_MODE=1 with a 4-bit counter.
module tb_nios_usb_gpx_conditioner;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic gpx_pin = 1'b0;
   logic irq_en = 1'b0;
   logic event_clr = 1'b0;
   logic cnt_clr = 1'b0;

   logic clean0, rise0, fall0, flag0, irq0;
   logic clean1, rise1, fall1, flag1, irq1;
   logic [15:0] cnt0;
   logic [3:0]  cnt1;

   int n_tests = 0;
   int n_fail  = 0;
   int rc, fc;

`ifdef NIOS_USB_GPX_EDGE_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   nios_usb_gpx_conditioner u0 (
      .clk(clk), .reset_n(reset_n), .gpx_pin(gpx_pin), .irq_en(irq_en),
      .event_clr(event_clr), .cnt_clr(cnt_clr), .gpx_clean(clean0),
      .rise_pulse(rise0), .fall_pulse(fall0), .event_flag(flag0),
      .irq(irq0), .edge_count(cnt0)
   );

   nios_usb_gpx_conditioner #(.EDGE_MODE(1), .CNT_W(4)) u1 (
      .clk(clk), .reset_n(reset_n), .gpx_pin(gpx_pin), .irq_en(irq_en),
      .event_clr(event_clr), .cnt_clr(cnt_clr), .gpx_clean(clean1),
      .rise_pulse(rise1), .fall_pulse(fall1), .event_flag(flag1),
      .irq(irq1), .edge_count(cnt1)
   );

   // Reference: the filtered level flips once the last four synchronised
   // samples (pin samples 2..5 edges old) all differ from it.
   logic [5:0] hist;
   logic       m_clean, m_rise, m_fall, m_f0, m_f1;
   int         m_cnt;
   logic       win;

   assign win = (hist[4:1] == {4{~m_clean}});

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist    <= '0;
         m_clean <= 1'b0;
         m_rise  <= 1'b0;
         m_fall  <= 1'b0;
         m_f0    <= 1'b0;
         m_f1    <= 1'b0;
         m_cnt   <= 0;
      end else begin
         hist <= {hist[4:0], gpx_pin};
         if (win) m_clean <= ~m_clean;
         m_rise <= win & ~m_clean;
         m_fall <= win & m_clean;
         if (m_rise | m_fall) m_f0 <= 1'b1;
         else if (event_clr)  m_f0 <= 1'b0;
         if (m_fall)          m_f1 <= 1'b1;
         else if (event_clr)  m_f1 <= 1'b0;
         if (cnt_clr) m_cnt <= (m_rise | m_fall) ? 1 : 0;
         else         m_cnt <= m_cnt + ((m_rise | m_fall) ? 1 : 0);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail < 40)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("m_clean0", 32'(clean0), 32'(m_clean));
      chk("m_rise0",  32'(rise0),  32'(m_rise));
      chk("m_fall0",  32'(fall0),  32'(m_fall));
      chk("m_flag0",  32'(flag0),  32'(m_f0));
      chk("m_irq0",   32'(irq0),   32'(m_f0 & irq_en));
      chk("m_clean1", 32'(clean1), 32'(m_clean));
      chk("m_flag1",  32'(flag1),  32'(m_f1));
      chk("m_irq1",   32'(irq1),   32'(m_f1 & irq_en));
      chk("m_cnt0",   32'(cnt0),   CNT_ON ? 32'(16'(m_cnt)) : 32'd0);
      chk("m_cnt1",   32'(cnt1),   CNT_ON ? 32'(m_cnt[3:0]) : 32'd0);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         tick(1);
         rc += int'(rise0);
         fc += int'(fall0);
      end
   endtask

   typedef struct {
      logic base;
      int   width;
      int   exp_r;
      int   exp_f;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{1'b0, 1, 0, 0};
      tbl[1] = '{1'b0, 3, 0, 0};
      tbl[2] = '{1'b0, 4, 1, 1};
      tbl[3] = '{1'b0, 6, 1, 1};
      tbl[4] = '{1'b1, 2, 0, 0};
      tbl[5] = '{1'b1, 3, 0, 0};
      tbl[6] = '{1'b1, 4, 1, 1};
      tbl[7] = '{1'b1, 9, 1, 1};

      // T1: reset held while the pin toggles
      for (int i = 0; i < 6; i++) begin
         gpx_pin = ~gpx_pin;
         tick(1);
         chk("t1_clean", 32'(clean0), 32'd0);
         chk("t1_pulse", 32'(rise0 | fall0), 32'd0);
         chk("t1_flag",  32'(flag0 | irq0), 32'd0);
      end
      gpx_pin = 1'b0;
      tick(2);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("t1_idle", 32'({clean0, rise0, fall0, flag0}), 32'd0);
      end

      // T2: latency and pulse width
      irq_en  = 1'b1;
      gpx_pin = 1'b1;
      tick(5);
      chk("t2_early_clean", 32'(clean0), 32'd0);
      chk("t2_early_rise",  32'(rise0),  32'd0);
      tick(1);
      chk("t2_clean", 32'(clean0), 32'd1);
      chk("t2_rise",  32'(rise0),  32'd1);
      tick(1);
      chk("t2_width", 32'(rise0), 32'd0);
      chk("t2_flag",  32'(flag0), 32'd1);
      chk("t2_irq",   32'(irq0),  32'd1);
      chk("t2_flag1", 32'(flag1), 32'd0);

      // T4: clear coincident with a fall on the fall-only instance
      event_clr = 1'b1;
      tick(1);
      event_clr = 1'b0;
      gpx_pin   = 1'b0;
      tick(6);
      chk("t4_fall1", 32'(fall1), 32'd1);
      event_clr = 1'b1;
      tick(1);
      chk("t4_race_flag", 32'(flag1), 32'd1);
      chk("t4_race_irq",  32'(irq1),  32'd1);
      tick(1);
      chk("t4_clr_flag", 32'(flag1), 32'd0);
      chk("t4_clr_irq",  32'(irq1),  32'd0);
      event_clr = 1'b0;

      // T3 and friends: glitch widths from the table
      foreach (tbl[i]) begin
         gpx_pin = tbl[i].base;
         run(12);
         rc = 0;
         fc = 0;
         gpx_pin = ~tbl[i].base;
         run(tbl[i].width);
         gpx_pin = tbl[i].base;
         run(12);
         chk($sformatf("tbl%0d_rise", i), 32'(rc), 32'(tbl[i].exp_r));
         chk($sformatf("tbl%0d_fall", i), 32'(fc), 32'(tbl[i].exp_f));
      end

      // Random traffic against the model
      for (int s = 0; s < 400; s++) begin
         gpx_pin = 1'($urandom_range(0, 1));
         for (int c = 0; c < int'($urandom_range(1, 8)); c++) begin
            irq_en    = 1'($urandom_range(0, 1));
            event_clr = ($urandom_range(0, 7) == 0);
            cnt_clr   = ($urandom_range(0, 15) == 0);
            tick(1);
         end
      end
      event_clr = 1'b0;
      cnt_clr   = 1'b0;

      // T5: counter wrap and clear race
      gpx_pin = 1'b0;
      run(12);
      cnt_clr = 1'b1;
      tick(1);
      cnt_clr = 1'b0;
      tick(1);
      chk("t5_zero", 32'(cnt1), 32'd0);
      for (int i = 0; i < 15; i++) begin
         gpx_pin = ~gpx_pin;
         tick(8);
      end
      chk("t5_fifteen", 32'(cnt1), CNT_ON ? 32'd15 : 32'd0);
      gpx_pin = ~gpx_pin;
      tick(8);
      chk("t5_wrap",  32'(cnt1), 32'd0);
      chk("t5_wide",  32'(cnt0), CNT_ON ? 32'd16 : 32'd0);
      gpx_pin = 1'b1;
      tick(8);
      chk("t5_one", 32'(cnt1), CNT_ON ? 32'd1 : 32'd0);
      gpx_pin = 1'b0;
      tick(6);
      cnt_clr = 1'b1;
      tick(1);
      cnt_clr = 1'b0;
      chk("t5_clr_race", 32'(cnt1), CNT_ON ? 32'd1 : 32'd0);

      // T6: reset while PENDING
      run(12);
      gpx_pin = 1'b1;
      tick(4);
      reset_n = 1'b0;
      #1;
      chk("t6_clean", 32'(clean0), 32'd0);
      chk("t6_outs",  32'({rise0, fall0, flag0, irq0}), 32'd0);
      tick(2);
      reset_n = 1'b1;
      tick(5);
      chk("t6_early", 32'(clean0), 32'd0);
      tick(1);
      chk("t6_clean_up", 32'(clean0), 32'd1);
      chk("t6_rise",     32'(rise0),  32'd1);
      tick(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
